// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// instruction-bus read, and presents if_pc / if_insn / if_en to the ID stage.
//
// Handshake: ibus_req is held high with ibus_addr stable until the cycle in
// which ibus_rdy=1; in that cycle the read is accepted and ibus_rd_data is
// valid.  ibus_rdy is ignored whenever ibus_req=0.  Reset may drop ibus_req
// mid-transaction; the bus tolerates that.
//
// States:
//   ST_FETCH - request outstanding, returned data goes to the IF register.
//   ST_DROP  - request outstanding for a fetch killed by flush; its data is
//              thrown away when it arrives.
//   ST_HOLD  - a returned instruction is parked in the one-entry buffer
//              because ID was stalled; no request is issued.
module if_fetch_stage #(
  parameter int                 ADDR_W       = 30,
  parameter int                 DATA_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = 30'h0,
  parameter logic [DATA_W-1:0]  NOP_INSN     = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_rdy,
  input  logic [DATA_W-1:0] ibus_rd_data,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DROP  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // All PC arithmetic is ADDR_W bits and wraps naturally.
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] next_pc_nxt;
  logic [DATA_W-1:0] hold_insn;
  logic [DATA_W-1:0] hold_insn_nxt;
  logic [ADDR_W-1:0] hold_pc;
  logic [ADDR_W-1:0] hold_pc_nxt;
  logic [ADDR_W-1:0] if_pc_nxt;
  logic [DATA_W-1:0] if_insn_nxt;
  logic              if_en_nxt;

  // Address of the fetch following the one on the bus, after applying a
  // taken branch.  A branch seen while stalled is ignored: ID re-evaluates
  // it once the stall clears.
  logic [ADDR_W-1:0] redirect_pc;

  // Bus request is combinational on state so reset kills it immediately.
  always_comb begin
    ibus_req  = (state != ST_HOLD) && !reset;
    ibus_addr = fetch_pc;
  end

  // Next-state and next-register computation; flush outranks stall and branch.
  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    next_pc_nxt   = next_pc;
    hold_insn_nxt = hold_insn;
    hold_pc_nxt   = hold_pc;
    if_pc_nxt     = if_pc;
    if_insn_nxt   = if_insn;
    if_en_nxt     = if_en;
    redirect_pc   = (br_taken && !stall) ? br_addr : next_pc;

    case (state)
      ST_FETCH: begin
        if (flush) begin
          if_en_nxt = 1'b0;
          if (ibus_rdy) begin
            // Returned data is discarded; restart at the flush target.
            fetch_pc_nxt = new_pc;
            next_pc_nxt  = new_pc + PC_ONE;
          end else begin
            // Keep the address stable until the killed read completes.
            next_pc_nxt = new_pc;
            state_nxt   = ST_DROP;
          end
        end else if (ibus_rdy) begin
          if (stall) begin
            // ID cannot take it: park the instruction, keep fetching later.
            hold_insn_nxt = ibus_rd_data;
            hold_pc_nxt   = fetch_pc + PC_ONE;
            fetch_pc_nxt  = next_pc;
            next_pc_nxt   = next_pc + PC_ONE;
            state_nxt     = ST_HOLD;
          end else begin
            // Deliver; a branch this cycle makes the delivered word its
            // delay slot and the next request goes to the target.
            if_insn_nxt  = ibus_rd_data;
            if_pc_nxt    = fetch_pc + PC_ONE;
            if_en_nxt    = 1'b1;
            fetch_pc_nxt = redirect_pc;
            next_pc_nxt  = redirect_pc + PC_ONE;
          end
        end else begin
          // Waiting on the bus: remember a branch target, bubble ID.
          next_pc_nxt = redirect_pc;
          if (!stall) begin
            if_en_nxt = 1'b0;
          end
        end
      end

      ST_DROP: begin
        if_en_nxt = 1'b0;
        if (flush) begin
          if (ibus_rdy) begin
            fetch_pc_nxt = new_pc;
            next_pc_nxt  = new_pc + PC_ONE;
            state_nxt    = ST_FETCH;
          end else begin
            next_pc_nxt = new_pc;
          end
        end else if (ibus_rdy) begin
          // Killed read finished; its data is dropped.
          fetch_pc_nxt = next_pc;
          next_pc_nxt  = next_pc + PC_ONE;
          state_nxt    = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (flush) begin
          if_en_nxt    = 1'b0;
          fetch_pc_nxt = new_pc;
          next_pc_nxt  = new_pc + PC_ONE;
          state_nxt    = ST_FETCH;
        end else if (!stall) begin
          // Release the parked instruction to ID and resume fetching.
          if_insn_nxt = hold_insn;
          if_pc_nxt   = hold_pc;
          if_en_nxt   = 1'b1;
          state_nxt   = ST_FETCH;
          if (br_taken) begin
            fetch_pc_nxt = br_addr;
            next_pc_nxt  = br_addr + PC_ONE;
          end
        end
      end

      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      fetch_pc  <= RESET_VECTOR;
      next_pc   <= RESET_VECTOR + PC_ONE;
      hold_insn <= NOP_INSN;
      hold_pc   <= '0;
      if_pc     <= '0;
      if_insn   <= NOP_INSN;
      if_en     <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      next_pc   <= next_pc_nxt;
      hold_insn <= hold_insn_nxt;
      hold_pc   <= hold_pc_nxt;
      if_pc     <= if_pc_nxt;
      if_insn   <= if_insn_nxt;
      if_en     <= if_en_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_if_fetch_stage;

  localparam int AW = 30;
  localparam int DW = 32;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic          br_taken;
  logic [AW-1:0] br_addr;
  logic          ibus_req;
  logic [AW-1:0] ibus_addr;
  logic          ibus_rdy;
  logic [DW-1:0] ibus_rd_data;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_insn;
  logic          if_en;

  if_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .br_taken     (br_taken),
    .br_addr      (br_addr),
    .ibus_req     (ibus_req),
    .ibus_addr    (ibus_addr),
    .ibus_rdy     (ibus_rdy),
    .ibus_rd_data (ibus_rd_data),
    .if_pc        (if_pc),
    .if_insn      (if_insn),
    .if_en        (if_en)
  );

  // Memory: word = address xor salt, or a forced word for one scenario
  logic          use_fixed;
  logic [DW-1:0] fixed_word;
  logic [DW-1:0] salt;

  always_comb begin
    ibus_rd_data = use_fixed ? fixed_word : ({2'b00, ibus_addr} ^ salt);
  end

  function automatic logic [DW-1:0] bus_word(input logic [AW-1:0] a);
    return use_fixed ? fixed_word : ({2'b00, a} ^ salt);
  endfunction

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the instruction stream seen from ID.
  //   m_addr    - address currently requested on the bus
  //   m_after   - address to request after that one
  //   m_discard - the outstanding read was killed by a flush
  //   held_q    - instructions returned while ID was stalled (at most one)
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] insn;
  } held_t;

  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_after;
  logic          m_discard;
  held_t         held_q[$];
  logic [AW-1:0] m_if_pc;
  logic [DW-1:0] m_if_insn;
  logic          m_if_en;

  task automatic model_reset();
    m_addr    = 30'h0;
    m_after   = 30'h1;
    m_discard = 1'b0;
    held_q.delete();
    m_if_pc   = 30'h0;
    m_if_insn = 32'h0;
    m_if_en   = 1'b0;
  endtask

  task automatic model_step();
    logic [AW-1:0] tgt;
    held_t         h;
    if (reset) begin
      model_reset();
    end else if (flush) begin
      m_if_en = 1'b0;
      if (held_q.size() != 0 || ibus_rdy) begin
        held_q.delete();
        m_addr    = new_pc;
        m_after   = new_pc + 30'd1;
        m_discard = 1'b0;
      end else begin
        m_after   = new_pc;
        m_discard = 1'b1;
      end
    end else if (held_q.size() != 0) begin
      if (!stall) begin
        h         = held_q.pop_front();
        m_if_pc   = h.pc;
        m_if_insn = h.insn;
        m_if_en   = 1'b1;
        if (br_taken) begin
          m_addr  = br_addr;
          m_after = br_addr + 30'd1;
        end
      end
    end else begin
      tgt = (br_taken && !stall && !m_discard) ? br_addr : m_after;
      if (ibus_rdy) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_addr    = m_after;
          m_after   = m_after + 30'd1;
        end else if (stall) begin
          h.pc   = m_addr + 30'd1;
          h.insn = bus_word(m_addr);
          held_q.push_back(h);
          m_addr  = m_after;
          m_after = m_after + 30'd1;
        end else begin
          m_if_insn = bus_word(m_addr);
          m_if_pc   = m_addr + 30'd1;
          m_if_en   = 1'b1;
          m_addr    = tgt;
          m_after   = tgt + 30'd1;
        end
      end else begin
        m_after = tgt;
        if (!stall) m_if_en = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_req;
    exp_req = !reset && (held_q.size() == 0);
    check_val("ibus_req", {31'b0, ibus_req}, {31'b0, exp_req});
    if (exp_req) check_val("ibus_addr", {2'b00, ibus_addr}, {2'b00, m_addr});
    check_val("if_en", {31'b0, if_en}, {31'b0, m_if_en});
    check_val("if_pc", {2'b00, if_pc}, {2'b00, m_if_pc});
    check_val("if_insn", if_insn, m_if_insn);
  endtask

  // Driver: check outputs, apply one cycle of inputs, advance the model,
  // then step to #1 after the next rising edge.
  task automatic cyc(input logic r, input logic st, input logic fl, input logic [AW-1:0] np,
                     input logic bt, input logic [AW-1:0] ba, input logic rd);
    check_outputs();
    reset    = r;
    stall    = st;
    flush    = fl;
    new_pc   = np;
    br_taken = bt;
    br_addr  = ba;
    ibus_rdy = rd;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    stall      = 1'b0;
    flush      = 1'b0;
    new_pc     = '0;
    br_taken   = 1'b0;
    br_addr    = '0;
    ibus_rdy   = 1'b0;
    use_fixed  = 1'b0;
    fixed_word = 32'hDEADBEEF;
    salt       = 32'h0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state, then zero-wait fetch with data == address
    cyc(1, 0, 0, 0, 0, 0, 1);
    check_val("rst_if_en", {31'b0, if_en}, 32'h0);
    check_val("rst_if_insn", if_insn, 32'h0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 1);

    // Three-cycle bus latency
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0, (i % 3) == 2);

    // Branch while fetching address 5: 5 is the delay slot, then 0x40
    cyc(0, 0, 1, 30'h3, 0, 0, 1);
    for (int i = 0; i < 8 && m_addr != 30'h5; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 30'h40, 1);
    check_val("br_slot_pc", {2'b00, if_pc}, 32'h6);
    check_val("br_slot_insn", if_insn, 32'h5);
    check_val("br_target", {2'b00, ibus_addr}, 32'h40);

    // Flush while the read of address 7 is still pending
    cyc(0, 0, 1, 30'h7, 0, 0, 1);
    cyc(0, 0, 1, 30'h100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 30'h55, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("flush_en", {31'b0, if_en}, 32'h0);
    check_val("flush_target", {2'b00, ibus_addr}, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("flush_pc", {2'b00, if_pc}, 32'h101);

    // Stall as 0xDEADBEEF returns, hold 4 cycles, release
    cyc(0, 0, 1, 30'h20, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    use_fixed = 1'b1;
    cyc(0, 1, 0, 0, 0, 0, 1);
    use_fixed = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 30'h99, 1);
    check_val("stall_req", {31'b0, ibus_req}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("stall_insn", if_insn, 32'hDEADBEEF);
    check_val("stall_pc", {2'b00, if_pc}, 32'h22);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // PC wrap at the top of the address space
    cyc(0, 0, 1, 30'h3FFFFFFF, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("wrap_pc", {2'b00, if_pc}, 32'h0);
    check_val("wrap_addr", {2'b00, ibus_addr}, 32'h0);

    // Reset in the middle of an outstanding request
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check_val("midrst_req", {31'b0, ibus_req}, 32'h0);
    check_val("midrst_en", {31'b0, if_en}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic
    salt = $urandom();
    for (int i = 0; i < 3000; i++) begin
      logic          r, st, fl, bt, rd;
      logic [AW-1:0] np, ba;
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 5) == 0);
      rd = ($urandom_range(0, 2) != 0);
      np = ($urandom_range(0, 3) == 0) ? (30'h3FFFFFFC + 30'($urandom_range(0, 3))) : 30'($urandom());
      ba = ($urandom_range(0, 3) == 0) ? (30'h3FFFFFFE + 30'($urandom_range(0, 1))) : 30'($urandom());
      if (i % 500 == 0) salt = $urandom();
      cyc(r, st, fl, np, bt, ba, rd);
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
